fifo_pkt_reader: RTL
====================

# fifo_pkt_reader

Read-side drainer for the 2048x8b camera-data async FIFO in the OV5640-to-UDP path. It sits in the UDP transmit clock domain and watches the FIFO read water level. When a full payload is buffered, it requests a UDP packet, then feeds payload bytes to the UDP transmitter on its byte-request strobe. It also counts packets sent and flags requests it could not serve (underrun).

## Interface
Parameters:
- `DATA_W`, 8: FIFO and payload byte width.
- `LVL_W`, 12: width of the FIFO read water level (depth width + 1).
- `PKT_LEN`, 1024: payload bytes per full packet; range 1..2^(LVL_W-1).
- `GAP_CYC`, 16: idle cycles enforced after each `tx_done`; range 1..65535.
- `TIMEOUT_CYC`, 65535: partial-flush timeout. Used only with `FIFO_PKT_TIMEOUT_EN`.

Ports:
- `rd_clk`  in  1: sole clock, the FIFO read clock.
- `rd_rst_n`  in  1: reset, asynchronous, active-low.
- `fifo_rd_en`  out  1: FIFO read enable; read data returns one cycle later.
- `fifo_rd_data`  in  DATA_W: FIFO read data.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_level`  in  LVL_W: FIFO read water level, in bytes.
- `tx_start`  out  1: one-cycle packet request to the UDP transmitter.
- `tx_byte_num`  out  16: payload length of the current packet.
- `tx_busy`  in  1: UDP transmitter busy.
- `tx_req`  in  1: UDP transmitter asks for the next byte; the byte is expected the following cycle.
- `tx_data`  out  DATA_W: payload byte.
- `tx_done`  in  1: one-cycle pulse, packet fully sent.
- `pkt_cnt`  out  16: packets completed; wraps 0xFFFF→0.
- `underrun`  out  1: sticky; a `tx_req` could not be served.

## Operation
FSM states: IDLE, START, SEND, GAP.

- **IDLE**
  - When `fifo_rd_level >= PKT_LEN` (level zero-extended to 16 bits) and `!tx_busy`: latch `tx_byte_num = PKT_LEN`, load `remain = PKT_LEN`, go to START.
- **START**
  - `tx_start = 1` for exactly this cycle, then go to SEND.
- **SEND**
  - `fifo_rd_en = tx_req & (remain != 0) & !fifo_empty`, combinational.
  - Each granted read decrements `remain`.
  - Registered `ok_q` captures the grant. `tx_data = ok_q ? fifo_rd_data : 0`.
  - A `tx_req` that is not granted sets `underrun`. The FIFO is not read, and `tx_data` is 0 the next cycle.
  - `tx_done` increments `pkt_cnt` and moves the FSM to GAP. `tx_done` is ignored in any other state.
- **GAP**
  - Count `GAP_CYC` cycles, then return to IDLE.
- `tx_req` outside SEND never drives `fifo_rd_en` and does not set `underrun`.
- If `tx_req` and `tx_done` arrive in the same cycle, both take effect.
- The FIFO level may rise during SEND; it is only evaluated in IDLE.
- Reset, including mid-packet: the FSM goes to IDLE immediately. These outputs become 0: `fifo_rd_en`, `tx_start`, `tx_byte_num`, `tx_data`, `pkt_cnt`, `underrun`. Internal `remain`, `ok_q` and the gap and timeout counters also clear.
  - FIFO contents are not touched; the FIFO has its own reset owner.
  - Any bytes of a partial packet left in the FIFO are sent as part of the next packet.

## Timing
- The IDLE condition is sampled at edge N. `tx_start` is high during cycle N+1 (registered). `tx_byte_num` is stable from cycle N+1 until the next START.
- `fifo_rd_en` has zero-cycle latency from `tx_req`. `tx_data` is valid in the cycle after `tx_req`, matching the FIFO's single-cycle read latency (no output register).
- `underrun` rises at the edge after the failing `tx_req`.
- Minimum spacing from `tx_done` to the next `tx_start` is `GAP_CYC` + 2 cycles.

## Configuration
- Macro `FIFO_PKT_TIMEOUT_EN`.
- **Defined:** a 16-bit idle counter runs in IDLE while `0 < fifo_rd_level < PKT_LEN`. It clears on any other level, or on leaving IDLE.
  - When the counter reaches `TIMEOUT_CYC` and `!tx_busy`, latch `tx_byte_num = fifo_rd_level` (snapshot) and go to START. This flushes the end-of-frame remainder.
- **Undefined:** no counter exists. Partial data waits until `PKT_LEN` bytes are buffered.

## Test plan
- Reset with `rd_rst_n` = 0 → all outputs 0 and FSM in IDLE; hold 10 cycles, no `tx_start`.
- Preload 1024 bytes with pattern i mod 256, `tx_busy` = 0 → one `tx_start`, `tx_byte_num` = 1024, 1024 `tx_req` return 0x00..0xFF×4 in order. After `tx_done`, `pkt_cnt` = 1 and `underrun` = 0.
- Level at 1023 → no start for 10000 cycles when the macro is undefined. With the macro and `TIMEOUT_CYC` = 100 → `tx_start` follows 100 cycles in IDLE, with `tx_byte_num` = 1023.
- Level at 1024 with `tx_busy` = 1 for 50 cycles → no start. `tx_start` is high one cycle after `tx_busy` falls.
- 1025th `tx_req` in the same packet, or a `tx_req` with `fifo_empty` = 1 → `fifo_rd_en` stays 0, `tx_data` = 0 next cycle, `underrun` = 1 and held until reset.
- `rd_rst_n` low after byte 500 of 1024 → outputs 0 in the same cycle. After release with 524 bytes left, refill to ≥1024 → a new packet starts cleanly, `pkt_cnt` counts from 0.

Source files
------------

// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkt_reader
//  Purpose  : Drains the camera async FIFO into UDP packets on the read clock;
//             optional end-of-frame flush enabled by FIFO_PKT_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_pkt_reader #(
    parameter int DATA_W      = 8,
    parameter int LVL_W       = 12,
    parameter int PKT_LEN     = 1024,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic              tx_start,
    output logic [15:0]       tx_byte_num,
    input  logic              tx_busy,
    input  logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic [15:0]       pkt_cnt,
    output logic              underrun
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_START = 2'd1;
    localparam logic [1:0]  S_SEND  = 2'd2;
    localparam logic [1:0]  S_GAP   = 2'd3;
    localparam logic [15:0] c_pkt_len  = 16'(PKT_LEN);
    localparam logic [15:0] c_gap_last = 16'(GAP_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_remain;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_byte_num;
    logic [15:0] r_pkt_cnt;
    logic        r_ok_q;
    logic        r_underrun;
    logic [15:0] w_level;
    logic        w_pkt_ready;
    logic        w_flush;
    logic        w_grant;
    logic        w_miss;

    assign w_level     = 16'(fifo_rd_level);
    assign w_pkt_ready = (w_level >= c_pkt_len) && !tx_busy;
    assign w_grant     = (r_state == S_SEND) && tx_req && (r_remain != 16'd0) && !fifo_empty;
    assign w_miss      = (r_state == S_SEND) && tx_req && !w_grant;

`ifdef FIFO_PKT_TIMEOUT_EN
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYC);
    logic [15:0] r_idle_cnt;
    logic        w_partial;

    assign w_partial = (w_level != 16'd0) && (w_level < c_pkt_len);
    assign w_flush   = (r_state == S_IDLE) && w_partial && (r_idle_cnt == c_timeout) && !tx_busy;

    // Saturates at the timeout so a busy transmitter just defers the flush.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_idle_cnt <= 16'd0;
        end else if ((r_state != S_IDLE) || !w_partial || w_flush) begin
            r_idle_cnt <= 16'd0;
        end else if (r_idle_cnt != c_timeout) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT_CYC);
    assign w_flush          = 1'b0;
`endif

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pkt_ready || w_flush) w_state_nxt = S_START;
            S_START: w_state_nxt = S_SEND;
            S_SEND:  if (tx_done) w_state_nxt = S_GAP;
            S_GAP:   if (r_gap_cnt == c_gap_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_remain   <= 16'd0;
            r_gap_cnt  <= 16'd0;
            r_byte_num <= 16'd0;
            r_pkt_cnt  <= 16'd0;
            r_ok_q     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ok_q <= w_grant;
            if (w_miss) begin
                r_underrun <= 1'b1;
            end
            // A full packet wins over a flush; both snapshot the length once.
            if ((r_state == S_IDLE) && w_pkt_ready) begin
                r_byte_num <= c_pkt_len;
                r_remain   <= c_pkt_len;
            end else if (w_flush) begin
                r_byte_num <= w_level;
                r_remain   <= w_level;
            end else if (w_grant) begin
                r_remain <= r_remain - 16'd1;
            end
            if ((r_state == S_SEND) && tx_done) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            r_gap_cnt <= (r_state == S_GAP) ? (r_gap_cnt + 16'd1) : 16'd0;
        end
    end

    always_comb begin
        fifo_rd_en  = w_grant;
        tx_start    = (r_state == S_START);
        tx_byte_num = r_byte_num;
        tx_data     = r_ok_q ? fifo_rd_data : '0;
        pkt_cnt     = r_pkt_cnt;
        underrun    = r_underrun;
    end

endmodule
`default_nettype wire
